// File: rtl/i2c_master_burst.sv
// Burst I2C master: START, address byte, N write or read bytes with ACK handling, STOP.
// SCL is push-pull; SDA is open-drain (driven low or released).
module i2c_master_burst #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [6:0]       i_addr,
  input  logic             i_rw,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_tx_data,
  output logic             o_tx_req,
  output logic [7:0]       o_rx_data,
  output logic             o_rx_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nack,
  output logic             o_scl,
  inout  wire              io_sda
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP, DONE
  } state_t;

  state_t           state, next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt;
  logic [LEN_W-1:0] bytes_left;
  logic [7:0]       sh;
  logic [7:0]       rx_sh;
  logic             rw_r;
  logic             ack_r;
  logic             sda_oe;
  logic             q_end, bit_end, smp, byte_end, more, running;

  assign q_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_end  = q_end && (qtr == 2'd3);
  assign smp      = q_end && (qtr == 2'd2);
  assign byte_end = bit_end && (bit_cnt == 3'd7);
  assign more     = (bytes_left > LEN_W'(1));
  assign running  = (state != IDLE) && (state != DONE);

  assign io_sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (i_start) next_state = START;
      START:     if (bit_end) next_state = ADDR;
      ADDR:      if (byte_end) next_state = ADDR_ACK;
      ADDR_ACK:  if (bit_end) next_state = ack_r ? STOP : (rw_r ? READ : WRITE);
      WRITE:     if (byte_end) next_state = WRITE_ACK;
      WRITE_ACK: if (bit_end) next_state = (!ack_r && more) ? WRITE : STOP;
      READ:      if (byte_end) next_state = READ_ACK;
      READ_ACK:  if (bit_end) next_state = more ? READ : STOP;
      STOP:      if (bit_end) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    o_scl    = qtr[1];
    sda_oe   = 1'b0;
    o_busy   = running;
    o_done   = (state == DONE);
    o_tx_req = bit_end && !ack_r &&
               (((state == ADDR_ACK) && !rw_r) || ((state == WRITE_ACK) && more));
    case (state)
      IDLE, DONE:  o_scl  = 1'b1;
      START: begin
        o_scl  = 1'b1;
        sda_oe = qtr[1];
      end
      ADDR, WRITE: sda_oe = !sh[3'd7 - bit_cnt];
      READ_ACK:    sda_oe = more;
      STOP:        sda_oe = (qtr != 2'd3);
      default:     sda_oe = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt    <= '0;
      qtr        <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      sh         <= '0;
      rx_sh      <= '0;
      rw_r       <= 1'b0;
      ack_r      <= 1'b0;
      o_nack     <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      if (running) begin
        if (q_end) begin
          div_cnt <= '0;
          qtr     <= qtr + 2'd1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
        qtr     <= '0;
      end

      if (state == IDLE)
        bit_cnt <= '0;
      else if (bit_end && ((state == ADDR) || (state == WRITE) || (state == READ)))
        bit_cnt <= bit_cnt + 3'd1;

      if ((state == IDLE) && i_start) begin
        sh         <= {i_addr, i_rw};
        rw_r       <= i_rw;
        bytes_left <= (i_len == '0) ? LEN_W'(1) : i_len;
        o_nack     <= 1'b0;
      end

      if (smp) begin
        ack_r <= io_sda;
        if (state == READ) rx_sh <= {rx_sh[6:0], io_sda};
      end

      if (o_tx_req) sh <= i_tx_data;

      if (bit_end && ack_r && ((state == ADDR_ACK) || (state == WRITE_ACK)))
        o_nack <= 1'b1;

      // Count only consumed bytes so N = 2^LEN_W-1 never wraps.
      if (bit_end && more && ((state == WRITE_ACK) || (state == READ_ACK)))
        bytes_left <= bytes_left - LEN_W'(1);

      o_rx_valid <= (state == READ) && byte_end;
      if ((state == READ) && byte_end) o_rx_data <= rx_sh;
    end
  end

endmodule
